// File: rtl/seg_scan_if.sv
// Bus bundle for seg_scan_ctrl: display data/load strobe in, scan outputs back.
// master = data source / display driver side, slave = scan controller.
interface seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic [3:0]              digit_out;
    logic                    seg_enable;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    frame_done;

    modport master (
        output digits_in, blank_in, load,
        input  digit_out, seg_enable, anode_n, frame_done
    );

    modport slave (
        input  digits_in, blank_in, load,
        output digit_out, seg_enable, anode_n, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: walks an active-low one-hot anode across
// NUM_DIGITS digits, with a blank gap at the start of every slot. Display
// data is double-buffered and committed only at the frame wrap.
// Optional leading-zero suppression: define LZ_SUPPRESS_EN.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam int unsigned SW = $clog2(NUM_DIGITS);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [SW-1:0]               slot_q, slot_d;
    logic [NUM_DIGITS-1:0][3:0]  act_q, act_d;
    logic [NUM_DIGITS-1:0]       actb_q, actb_d;
    logic [NUM_DIGITS-1:0][3:0]  pend_q, pend_d;
    logic [NUM_DIGITS-1:0]       pendb_q, pendb_d;
    logic                        pv_q, pv_d;
    logic                        wrap;

    logic [NUM_DIGITS-1:0]       anode_q, anode_d;
    logic                        en_q, en_d;
    logic [3:0]                  digit_q, digit_d;
    logic                        fd_q, fd_d;

`ifdef LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0]       lz_d;
    logic                        seen;

    // Leading-zero mask over the buffer that will be active next cycle
    always_comb begin
        lz_d = '0;
        seen = 1'b0;
        for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
            if (act_d[i] != 4'd0) seen = 1'b1;
            lz_d[i] = ~seen;
        end
    end
`endif

    // Next-state: slot timing, frame-boundary commit, pending capture, outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        slot_d  = slot_q;
        act_d   = act_q;
        actb_d  = actb_q;
        pend_d  = pend_q;
        pendb_d = pendb_q;
        pv_d    = pv_q;
        wrap    = 1'b0;

        case (state_q)
            BLANK: begin
                if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = SHOW;
            end
            SHOW: begin
                if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                    if (slot_q == SW'(NUM_DIGITS - 1)) begin
                        slot_d = '0;
                        wrap   = 1'b1;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            default: state_d = BLANK;
        endcase

        // Commit reads the old pending value before a same-cycle load overwrites it
        if (wrap && pv_q) begin
            act_d  = pend_q;
            actb_d = pendb_q;
            pv_d   = 1'b0;
        end
        if (bus.load) begin
            pend_d  = bus.digits_in;
            pendb_d = bus.blank_in;
            pv_d    = 1'b1;
        end

        // Outputs are built from next-cycle state so the registers carry no extra lag
        fd_d    = wrap;
        anode_d = '1;
        en_d    = 1'b0;
        digit_d = act_d[slot_d];
        if (state_d == SHOW) begin
            anode_d[slot_d] = 1'b0;
`ifdef LZ_SUPPRESS_EN
            en_d = ~actb_d[slot_d] & ~lz_d[slot_d];
`else
            en_d = ~actb_d[slot_d];
`endif
        end
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            slot_q  <= '0;
            act_q   <= '0;
            actb_q  <= '0;
            pend_q  <= '0;
            pendb_q <= '0;
            pv_q    <= 1'b0;
            anode_q <= '1;
            en_q    <= 1'b0;
            digit_q <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            act_q   <= act_d;
            actb_q  <= actb_d;
            pend_q  <= pend_d;
            pendb_q <= pendb_d;
            pv_q    <= pv_d;
            anode_q <= anode_d;
            en_q    <= en_d;
            digit_q <= digit_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.anode_n    = anode_q;
    assign bus.seg_enable = en_q;
    assign bus.digit_out  = digit_q;
    assign bus.frame_done = fd_q;
endmodule
